// File: rtl/rr_arb_mux.sv
// N-channel arbitrated multiplexer: round-robin or forced-select grant feeding
// a single registered output slot with valid/ready handshakes on every channel.
module rr_arb_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 2,
  parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               force_en,
  input  logic [SEL_W-1:0]   force_sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             space;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             f_vld;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // Grant selection and per-channel ready
  always_comb begin
    space      = !valid_q || out_ready;
    rr_vld     = 1'b0;
    rr_idx     = '0;
    f_vld      = 1'b0;
    in_ready   = '0;
    grant_data = '0;
    // Lowest valid index at or above ptr wins; otherwise wrap to lowest valid.
    for (int i = 0; i < int'(N); i++) begin
      if (!rr_vld && in_valid[i] && (SEL_W'(i) >= ptr_q)) begin
        rr_vld = 1'b1;
        rr_idx = SEL_W'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!rr_vld && in_valid[i]) begin
        rr_vld = 1'b1;
        rr_idx = SEL_W'(i);
      end
    end
    // Out-of-range force_sel matches no channel, so it yields no grant.
    for (int i = 0; i < int'(N); i++) begin
      if ((force_sel == SEL_W'(i)) && in_valid[i]) f_vld = 1'b1;
    end
    grant_vld = force_en ? f_vld : rr_vld;
    grant_idx = force_en ? force_sel : rr_idx;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready[i] = !rst && space && grant_vld;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
    xfer = |(in_valid & in_ready);
  end

  // Output slot and pointer next-state
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = grant_data;
      sel_d   = grant_idx;
      if (!force_en) begin
        ptr_d = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: N=2, N=4 and N=3 instances, expected output
// words queued when a grant is driven and popped when the word appears.
module tb_rr_arb_mux;

  logic clk;
  logic rst;

  logic [63:0]  a_data;
  logic [1:0]   a_iv, a_ir;
  logic         a_fe, a_ov, a_or;
  logic [0:0]   a_fs, a_os;
  logic [31:0]  a_od;

  logic [127:0] b_data;
  logic [3:0]   b_iv, b_ir;
  logic         b_fe, b_ov, b_or;
  logic [1:0]   b_fs, b_os;
  logic [31:0]  b_od;

  logic [95:0]  c_data;
  logic [2:0]   c_iv, c_ir;
  logic         c_fe, c_ov, c_or;
  logic [1:0]   c_fs, c_os;
  logic [31:0]  c_od;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] qc[$];

  int total = 0;
  int bad   = 0;

  rr_arb_mux #(.WIDTH(32), .N(2)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_iv), .in_ready(a_ir),
    .force_en(a_fe), .force_sel(a_fs), .out_data(a_od), .out_valid(a_ov),
    .out_ready(a_or), .out_sel(a_os));

  rr_arb_mux #(.WIDTH(32), .N(4)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_iv), .in_ready(b_ir),
    .force_en(b_fe), .force_sel(b_fs), .out_data(b_od), .out_valid(b_ov),
    .out_ready(b_or), .out_sel(b_os));

  rr_arb_mux #(.WIDTH(32), .N(3)) u_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_iv), .in_ready(c_ir),
    .force_en(c_fe), .force_sel(c_fs), .out_data(c_od), .out_valid(c_ov),
    .out_ready(c_or), .out_sel(c_os));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input int which, input string tag);
    logic [63:0] e;
    logic        ov;
    logic [31:0] od, os;
    bit          empty;
    e = '0;
    case (which)
      0: begin
        empty = (qa.size() == 0);
        if (!empty) e = qa.pop_front();
        ov = a_ov; od = a_od; os = 32'(a_os);
      end
      1: begin
        empty = (qb.size() == 0);
        if (!empty) e = qb.pop_front();
        ov = b_ov; od = b_od; os = 32'(b_os);
      end
      default: begin
        empty = (qc.size() == 0);
        if (!empty) e = qc.pop_front();
        ov = c_ov; od = c_od; os = 32'(c_os);
      end
    endcase
    if (empty) begin
      total++;
      bad++;
      $error("FAIL %s observed=no_entry expected=scoreboard_entry", tag);
    end else begin
      chk({tag, "_valid"}, 64'(ov), 64'd1);
      chk({tag, "_sel"}, 64'(os), {32'd0, e[63:32]});
      chk({tag, "_data"}, 64'(od), {32'd0, e[31:0]});
    end
  endtask

  task automatic a_step(input logic [1:0] v, input logic [1:0] rdy, input int g, input string tag);
    a_iv = v;
    #1;
    chk({tag, "_rdy"}, 64'(a_ir), 64'(rdy));
    if (g >= 0) qa.push_back({32'(g), a_data[g*32 +: 32]});
    tick();
    if (g >= 0) pop_chk(0, tag);
  endtask

  task automatic b_step(input logic [3:0] v, input logic [3:0] rdy, input int g, input string tag);
    b_iv = v;
    #1;
    chk({tag, "_rdy"}, 64'(b_ir), 64'(rdy));
    if (g >= 0) qb.push_back({32'(g), b_data[g*32 +: 32]});
    tick();
    if (g >= 0) pop_chk(1, tag);
  endtask

  task automatic c_step(input logic [2:0] v, input logic [2:0] rdy, input int g, input string tag);
    c_iv = v;
    #1;
    chk({tag, "_rdy"}, 64'(c_ir), 64'(rdy));
    if (g >= 0) qc.push_back({32'(g), c_data[g*32 +: 32]});
    tick();
    if (g >= 0) pop_chk(2, tag);
  endtask

  initial begin
    rst    = 1'b1;
    a_data = {32'hBBBB1111, 32'hAAAA0000};
    a_iv   = 2'b11; a_fe = 1'b0; a_fs = '0; a_or = 1'b1;
    b_data = {32'h40000003, 32'h40000002, 32'h40000001, 32'h40000000};
    b_iv   = '0; b_fe = 1'b0; b_fs = '0; b_or = 1'b1;
    c_data = {32'h50000002, 32'h50000001, 32'h50000000};
    c_iv   = '0; c_fe = 1'b0; c_fs = '0; c_or = 1'b1;

    // Reset with both channels requesting
    #1;
    chk("rst_rdy_t0", 64'(a_ir), 64'd0);
    tick();
    chk("rst_rdy_c1", 64'(a_ir), 64'd0);
    chk("rst_valid_c1", 64'(a_ov), 64'd0);
    chk("rst_data_c1", 64'(a_od), 64'd0);
    chk("rst_sel_c1", 64'(a_os), 64'd0);
    tick();
    chk("rst_rdy_c2", 64'(a_ir), 64'd0);
    chk("rst_valid_c2", 64'(a_ov), 64'd0);
    rst  = 1'b0;
    a_iv = 2'b00;
    tick();
    chk("idle_valid", 64'(a_ov), 64'd0);
    chk("idle_data", 64'(a_od), 64'd0);

    // Round-robin fairness: 0,1,0,1 back to back
    for (int k = 0; k < 4; k++) begin
      a_step(2'b11, (k % 2 == 0) ? 2'b01 : 2'b10, k % 2, "rr_fair");
    end

    // Backpressure: move ptr to 1, then first word from ch1 and stall it
    a_step(2'b01, 2'b01, 0, "bp_pre");
    a_data = {32'h12345678, 32'hCAFE0000};
    a_step(2'b11, 2'b10, 1, "bp_first");
    a_or = 1'b0;
    #1;
    chk("bp_rdy_stall", 64'(a_ir), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_valid", 64'(a_ov), 64'd1);
      chk("bp_hold_sel", 64'(a_os), 64'd1);
      chk("bp_hold_data", 64'(a_od), 64'h12345678);
      chk("bp_hold_rdy", 64'(a_ir), 64'd0);
    end
    a_or = 1'b1;
    a_step(2'b11, 2'b01, 0, "bp_resume");

    // Forced select of ch1 with ptr at 1; ptr must stay at 1
    a_fe = 1'b1;
    a_fs = 1'b1;
    a_data = {32'h11110001, 32'h0000AAAA};
    a_step(2'b11, 2'b10, 1, "force_a");
    a_data = {32'h11110002, 32'h0000BBBB};
    a_step(2'b11, 2'b10, 1, "force_b");
    a_step(2'b01, 2'b00, -1, "force_none");
    chk("force_none_valid", 64'(a_ov), 64'd0);
    a_fe = 1'b0;
    a_data = {32'h22220001, 32'h33330000};
    a_step(2'b11, 2'b10, 1, "rr_after_force");

    // Reset in the middle of a stall; ptr is 1 beforehand
    a_step(2'b01, 2'b01, 0, "pre_stall");
    a_iv = 2'b00;
    a_or = 1'b0;
    tick();
    chk("stall_valid", 64'(a_ov), 64'd1);
    chk("stall_data", 64'(a_od), 64'h33330000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_stall_valid", 64'(a_ov), 64'd0);
    chk("rst_stall_sel", 64'(a_os), 64'd0);
    chk("rst_stall_data", 64'(a_od), 64'd0);
    a_or = 1'b1;
    a_step(2'b11, 2'b01, 0, "post_rst_ptr0");
    a_iv = 2'b00;
    tick();
    chk("drain_valid", 64'(a_ov), 64'd0);
    chk("drain_sel_hold", 64'(a_os), 64'd0);
    chk("qa_empty", 64'(qa.size()), 64'd0);

    // N=4 wrap-around: channels 0 and 3 alternate
    for (int k = 0; k < 4; k++) begin
      b_step(4'b1001, (k % 2 == 0) ? 4'b0001 : 4'b1000, (k % 2 == 0) ? 0 : 3, "wrap4");
    end

    // N=3: out-of-range force_sel, forced ch2, then round-robin from ptr 0
    c_fe = 1'b1;
    c_fs = 2'd3;
    c_step(3'b111, 3'b000, -1, "force_oor");
    chk("force_oor_valid", 64'(c_ov), 64'd0);
    c_fs = 2'd2;
    c_step(3'b111, 3'b100, 2, "force_c2");
    c_fe = 1'b0;
    c_step(3'b110, 3'b010, 1, "rr3_a");
    c_step(3'b110, 3'b100, 2, "rr3_b");
    c_step(3'b110, 3'b010, 1, "rr3_c");
    chk("qb_empty", 64'(qb.size()), 64'd0);
    chk("qc_empty", 64'(qc.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
